// File: rtl/iop_channel_sequencer_pkg.sv
// Shared definitions for the IOP channel sequencer: function codes, condition
// codes, well-known device slots, FSM encodings and the decoded request action.
package iop_channel_sequencer_pkg;

    localparam logic [2:0] FNC_SIO = 3'd0;
    localparam logic [2:0] FNC_TIO = 3'd1;
    localparam logic [2:0] FNC_TDV = 3'd2;
    localparam logic [2:0] FNC_HIO = 3'd3;
    localparam logic [2:0] FNC_AIO = 3'd6;

    localparam logic [1:0] CC_OK    = 2'b00;
    localparam logic [1:0] CC_BUSY  = 2'b01;
    localparam logic [1:0] CC_ERR   = 2'b10;
    localparam logic [1:0] CC_NODEV = 2'b11;

    localparam logic [7:0] DEV_CONSOLE   = 8'd1;
    localparam logic [7:0] DEV_PAPERTAPE = 8'd5;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_ACK  = 2'd1,
        REQ_WAIT = 2'd2
    } req_state_e;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    // Everything the request decoder tells the sequencer about one CPU request.
    typedef struct packed {
        logic [1:0] cc;
        logic [7:0] aio_device;
        logic       start;
        logic       halt;
        logic       aio_clear;
    } cc_action_t;

    // AIO reports the error flag in the high bit of the condition code.
    function automatic logic [1:0] aio_cc(input logic err);
        return {err, 1'b0};
    endfunction

endpackage

// File: rtl/iop_cc_decode.sv
// Combinational decode of a latched CPU I/O request against the current
// channel state into a condition code and the channel action it implies.
module iop_cc_decode
    import iop_channel_sequencer_pkg::*;
#(
    parameter int              NDEV         = 8,
    parameter logic [0:NDEV-1] PRESENT_MASK = '0,
    parameter logic [2:0]      IOP_NUM      = 3'd0
) (
    input  logic [2:0]      func_i,
    input  logic [21:31]    device_i,
    input  ch_state_e       ch_state_i,
    input  logic [7:0]      run_dev_i,
    input  logic            irq_i,
    input  logic            err_i,
    input  logic [7:0]      pend_dev_i,
    input  logic [0:NDEV-1] dev_err_i,
    output cc_action_t      act_o
);

    logic [7:0] dev_num;
    logic       slot_present;
    logic       dev_err_sel;
    logic       present;
    logic       running;

    always_comb begin
        dev_num      = device_i[24:31];
        slot_present = 1'b0;
        dev_err_sel  = 1'b0;
        // A device number beyond the last slot never matches, so it reads as absent.
        for (int i = 0; i < NDEV; i++) begin
            if (dev_num == 8'(i)) begin
                slot_present = PRESENT_MASK[i];
                dev_err_sel  = dev_err_i[i];
            end
        end
        present = (device_i[21:23] == IOP_NUM) && slot_present;
        running = (ch_state_i == CH_RUN) && (run_dev_i == dev_num);

        act_o    = '0;
        act_o.cc = CC_NODEV;
        case (func_i)
            FNC_SIO: begin
                if (!present) begin
                    act_o.cc = CC_NODEV;
                end else if ((ch_state_i != CH_IDLE) || irq_i) begin
                    act_o.cc = CC_BUSY;
                end else begin
                    act_o.cc    = CC_OK;
                    act_o.start = 1'b1;
                end
            end
            FNC_TIO, FNC_TDV: begin
                if (!present) begin
                    act_o.cc = CC_NODEV;
                end else if (running) begin
                    act_o.cc = CC_BUSY;
                end else if ((func_i == FNC_TDV) && dev_err_sel) begin
                    act_o.cc = CC_ERR;
                end else begin
                    act_o.cc = CC_OK;
                end
            end
            FNC_HIO: begin
                if (!present) begin
                    act_o.cc = CC_NODEV;
                end else begin
                    act_o.cc   = CC_OK;
                    act_o.halt = running;
                end
            end
            FNC_AIO: begin
                if (irq_i) begin
                    act_o.cc         = aio_cc(err_i);
                    act_o.aio_device = pend_dev_i;
                    act_o.aio_clear  = 1'b1;
                end else begin
                    act_o.cc = CC_NODEV;
                end
            end
            default: act_o.cc = CC_NODEV;
        endcase
    end

endmodule

// File: rtl/iop_channel_sequencer.sv
// IOP channel sequencer: acknowledges CPU I/O requests, runs one device
// controller at a time on the shared memory port, and reports completion by irq.
module iop_channel_sequencer
    import iop_channel_sequencer_pkg::*;
#(
    parameter int              NDEV         = 8,
    parameter logic [0:NDEV-1] PRESENT_MASK = 8'b0100_0100,
    parameter logic [2:0]      IOP_NUM      = 3'd0,
    parameter int              TIMEOUT      = 4096
) (
    input  logic            reset,
    input  logic            clock,
    input  logic            io_req,
    input  logic [0:2]      io_func,
    input  logic [21:31]    io_device,
    output logic            io_ack,
    output logic [0:1]      io_cc,
    output logic [0:7]      io_aio_device,
    output logic [0:NDEV-1] dev_active,
    input  logic [0:NDEV-1] dev_done,
    output logic            mem_owner,
    output logic            irq
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    req_state_e      req_state_q;
    logic [2:0]      func_q;
    logic [21:31]    device_q;
    logic            io_ack_q;

    ch_state_e       ch_state_q;
    logic [7:0]      run_dev_q;
    logic [7:0]      pend_dev_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [TW-1:0]   tmo_cnt_d;
    logic [0:NDEV-1] dev_active_q;
    logic [0:NDEV-1] dev_err_q;
    logic            mem_owner_q;
    logic            irq_q;
    logic            err_q;

    logic [0:NDEV-1] run_onehot;
    logic [0:NDEV-1] start_onehot;
    cc_action_t      act;
    logic            do_start;
    logic            do_halt;
    logic            do_aio_clear;
    logic            done_hit;
    logic            tmo_hit;
    logic            run_end;
    logic            end_err;

    generate
        for (genvar gi = 0; gi < NDEV; gi++) begin : g_slot
            assign run_onehot[gi]   = (run_dev_q == 8'(gi));
            assign start_onehot[gi] = (device_q[24:31] == 8'(gi));
        end
    endgenerate

    iop_cc_decode #(
        .NDEV         (NDEV),
        .PRESENT_MASK (PRESENT_MASK),
        .IOP_NUM      (IOP_NUM)
    ) u_cc_decode (
        .func_i     (func_q),
        .device_i   (device_q),
        .ch_state_i (ch_state_q),
        .run_dev_i  (run_dev_q),
        .irq_i      (irq_q),
        .err_i      (err_q),
        .pend_dev_i (pend_dev_q),
        .dev_err_i  (dev_err_q),
        .act_o      (act)
    );

    // Decoded actions take effect only on the single ack cycle.
    assign do_start     = io_ack_q && act.start;
    assign do_halt      = io_ack_q && act.halt;
    assign do_aio_clear = io_ack_q && act.aio_clear;

    // A completion pulse outranks a coincident timeout or halt.
    assign done_hit  = |(dev_done & run_onehot);
    assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign run_end   = (ch_state_q == CH_RUN) && (done_hit || tmo_hit || do_halt);
    assign end_err   = !done_hit;
    assign tmo_cnt_d = tmo_cnt_q + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_state_q <= REQ_IDLE;
            func_q      <= '0;
            device_q    <= '0;
            io_ack_q    <= 1'b0;
        end else begin
            case (req_state_q)
                REQ_IDLE: begin
                    if (io_req) begin
                        func_q      <= io_func;
                        device_q    <= io_device;
                        io_ack_q    <= 1'b1;
                        req_state_q <= REQ_ACK;
                    end
                end
                REQ_ACK: begin
                    io_ack_q    <= 1'b0;
                    req_state_q <= REQ_WAIT;
                end
                REQ_WAIT: begin
                    if (!io_req) begin
                        req_state_q <= REQ_IDLE;
                    end
                end
                default: begin
                    io_ack_q    <= 1'b0;
                    req_state_q <= REQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_state_q   <= CH_IDLE;
            run_dev_q    <= '0;
            pend_dev_q   <= '0;
            tmo_cnt_q    <= '0;
            dev_active_q <= '0;
            dev_err_q    <= '0;
            mem_owner_q  <= 1'b0;
            irq_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (do_aio_clear) begin
                irq_q <= 1'b0;
                err_q <= 1'b0;
            end
            case (ch_state_q)
                CH_IDLE: begin
                    if (do_start) begin
                        ch_state_q   <= CH_RUN;
                        run_dev_q    <= device_q[24:31];
                        tmo_cnt_q    <= '0;
                        dev_active_q <= start_onehot;
                        mem_owner_q  <= 1'b1;
                    end
                end
                CH_RUN: begin
                    if (run_end) begin
                        ch_state_q   <= CH_DRAIN;
                        dev_active_q <= '0;
                        mem_owner_q  <= 1'b0;
                        irq_q        <= 1'b1;
                        err_q        <= end_err;
                        pend_dev_q   <= run_dev_q;
                        dev_err_q    <= (dev_err_q & ~run_onehot)
                                      | (run_onehot & {NDEV{end_err}});
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                    end
                end
                CH_DRAIN: ch_state_q <= CH_IDLE;
                default:  ch_state_q <= CH_IDLE;
            endcase
        end
    end

    assign io_ack        = io_ack_q;
    assign io_cc         = io_ack_q ? act.cc : CC_OK;
    assign io_aio_device = io_ack_q ? act.aio_device : 8'd0;
    assign dev_active    = dev_active_q;
    assign mem_owner     = mem_owner_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_iop_channel_sequencer.sv
// Scoreboard bench for the IOP channel sequencer: requests push expected
// cc/device pairs, a monitor pops and compares on every io_ack.
module tb_iop_channel_sequencer;
    import iop_channel_sequencer_pkg::*;

    logic        reset;
    logic        clock;
    logic        io_req;
    logic [0:2]  io_func;
    logic [21:31] io_device;
    logic        io_ack;
    logic [0:1]  io_cc;
    logic [0:7]  io_aio_device;
    logic [0:7]  dev_active;
    logic [0:7]  dev_done;
    logic        mem_owner;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] cc;
        logic [7:0] aio;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    iop_channel_sequencer dut (
        .reset         (reset),
        .clock         (clock),
        .io_req        (io_req),
        .io_func       (io_func),
        .io_device     (io_device),
        .io_ack        (io_ack),
        .io_cc         (io_cc),
        .io_aio_device (io_aio_device),
        .dev_active    (dev_active),
        .dev_done      (dev_done),
        .mem_owner     (mem_owner),
        .irq           (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [0:7] onehot(input int d);
        logic [0:7] v;
        v    = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (io_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=cc%0b required=no_ack", io_cc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_cc", {30'b0, io_cc}, {30'b0, mon_e.cc});
                chk("ack_aio_device", {24'b0, io_aio_device}, {24'b0, mon_e.aio});
            end
        end
    end

    task automatic do_req(input logic [2:0] f, input logic [2:0] iop, input logic [7:0] d,
                          input logic [1:0] ecc, input logic [7:0] eaio, input int hold);
        exp_t e;
        int   n;
        repeat (2) @(negedge clock);
        e.cc  = ecc;
        e.aio = eaio;
        sb_q.push_back(e);
        io_func   = f;
        io_device = {iop, d};
        io_req    = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (io_ack !== 1'b1 && n < 10);
        chk("ack_latency", n, 1);
        repeat (hold) @(negedge clock);
        io_req = 1'b0;
        $display("req func=%0d dev=%0d -> expect cc=%0b aio=%0d", f, d, ecc, eaio);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset     = 1'b1;
        io_req    = 1'b0;
        io_func   = '0;
        io_device = '0;
        dev_done  = '0;
        repeat (2) @(negedge clock);
        chk("rst_ack", {31'b0, io_ack}, 0);
        chk("rst_cc", {30'b0, io_cc}, 0);
        chk("rst_aio", {24'b0, io_aio_device}, 0);
        chk("rst_active", {24'b0, dev_active}, 0);
        chk("rst_mem_owner", {31'b0, mem_owner}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        reset = 1'b0;

        // SIO to paper tape, normal completion
        do_req(FNC_SIO, 3'd0, DEV_PAPERTAPE, CC_OK, 8'd0, 0);
        @(negedge clock);
        chk("sio5_active", {24'b0, dev_active}, {24'b0, onehot(5)});
        chk("sio5_mem_owner", {31'b0, mem_owner}, 1);
        chk("sio5_irq_low", {31'b0, irq}, 0);
        dev_done = onehot(5);
        @(negedge clock);
        dev_done = '0;
        chk("drain5_active", {24'b0, dev_active}, 0);
        chk("drain5_mem_owner", {31'b0, mem_owner}, 0);
        chk("drain5_irq", {31'b0, irq}, 1);
        do_req(FNC_AIO, 3'd0, 8'd0, CC_OK, 8'd5, 0);
        @(negedge clock);
        chk("aio5_irq_clear", {31'b0, irq}, 0);

        // Absent targets, unknown func, AIO with nothing pending (held request)
        do_req(FNC_SIO, 3'd0, 8'd3, CC_NODEV, 8'd0, 0);
        do_req(FNC_SIO, 3'd1, DEV_PAPERTAPE, CC_NODEV, 8'd0, 0);
        do_req(FNC_SIO, 3'd0, 8'd9, CC_NODEV, 8'd0, 0);
        do_req(3'd7, 3'd0, DEV_CONSOLE, CC_NODEV, 8'd0, 0);
        do_req(FNC_AIO, 3'd0, 8'd0, CC_NODEV, 8'd0, 4);
        @(negedge clock);
        chk("absent_active", {24'b0, dev_active}, 0);

        // Console running: busy and status queries
        do_req(FNC_SIO, 3'd0, DEV_CONSOLE, CC_OK, 8'd0, 0);
        do_req(FNC_SIO, 3'd0, DEV_PAPERTAPE, CC_BUSY, 8'd0, 0);
        do_req(FNC_TIO, 3'd0, DEV_CONSOLE, CC_BUSY, 8'd0, 0);
        do_req(FNC_TIO, 3'd0, DEV_PAPERTAPE, CC_OK, 8'd0, 0);
        do_req(FNC_TDV, 3'd0, DEV_PAPERTAPE, CC_OK, 8'd0, 0);
        @(negedge clock);
        chk("run1_active", {24'b0, dev_active}, {24'b0, onehot(1)});

        // HIO aborts the console
        do_req(FNC_HIO, 3'd0, DEV_CONSOLE, CC_OK, 8'd0, 0);
        @(negedge clock);
        chk("hio_drain_active", {24'b0, dev_active}, 0);
        chk("hio_drain_mem_owner", {31'b0, mem_owner}, 0);
        chk("hio_irq", {31'b0, irq}, 1);
        do_req(FNC_AIO, 3'd0, 8'd0, CC_ERR, 8'd1, 0);
        @(negedge clock);
        chk("hio_aio_irq_clear", {31'b0, irq}, 0);
        do_req(FNC_TDV, 3'd0, DEV_CONSOLE, CC_ERR, 8'd0, 0);
        do_req(FNC_TIO, 3'd0, DEV_CONSOLE, CC_OK, 8'd0, 0);

        // Paper tape never finishes: timeout after exactly 4096 run cycles
        do_req(FNC_SIO, 3'd0, DEV_PAPERTAPE, CC_OK, 8'd0, 0);
        @(negedge clock);
        chk("tmo_first_active", {24'b0, dev_active}, {24'b0, onehot(5)});
        cnt = 0;
        while (dev_active !== 8'd0 && cnt < 5000) begin
            @(negedge clock);
            cnt++;
        end
        chk("timeout_cycles", cnt, 4096);
        chk("timeout_irq", {31'b0, irq}, 1);
        do_req(FNC_AIO, 3'd0, 8'd0, CC_ERR, 8'd5, 0);
        do_req(FNC_AIO, 3'd0, 8'd0, CC_NODEV, 8'd0, 0);

        // Completion and HIO in the same cycle: completion wins
        do_req(FNC_SIO, 3'd0, DEV_CONSOLE, CC_OK, 8'd0, 0);
        do_req(FNC_HIO, 3'd0, DEV_CONSOLE, CC_OK, 8'd0, 0);
        dev_done = onehot(1);
        @(negedge clock);
        dev_done = '0;
        chk("race_active", {24'b0, dev_active}, 0);
        chk("race_irq", {31'b0, irq}, 1);
        do_req(FNC_AIO, 3'd0, 8'd0, CC_OK, 8'd1, 0);
        do_req(FNC_TDV, 3'd0, DEV_CONSOLE, CC_OK, 8'd0, 0);

        // Asynchronous reset in mid-run
        do_req(FNC_SIO, 3'd0, DEV_PAPERTAPE, CC_OK, 8'd0, 0);
        @(negedge clock);
        chk("prereset_active", {24'b0, dev_active}, {24'b0, onehot(5)});
        #2;
        reset = 1'b1;
        #1;
        chk("async_active", {24'b0, dev_active}, 0);
        chk("async_mem_owner", {31'b0, mem_owner}, 0);
        chk("async_irq", {31'b0, irq}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("postreset_active", {24'b0, dev_active}, 0);
        chk("postreset_irq", {31'b0, irq}, 0);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iop_channel_sequencer.md
Name: iop_channel_sequencer

Overview:
- Sits between the CPU I/O instruction path and the IOP device controllers (console, paper tape).
- Decodes CPU I/O requests (SIO/TIO/TDV/HIO/AIO) and returns condition codes to the CPU.
- Grants one device controller at a time its active line and ownership of the shared memory port.
- Tracks completion, timeout and abort, and raises an interrupt that the CPU acknowledges with AIO.

Parameters:
- NDEV, 8: number of device slots on this IOP; device number 0..NDEV-1.
- PRESENT_MASK, 8'b0100_0100: bit d set means device d is present (bit 0 is MSB, so devices 1 and 5 are present).
- IOP_NUM, 3'd0: this IOP's number, compared against io_device[21:23].
- TIMEOUT, 4096: maximum cycles a device may stay active before it is aborted.

Ports:
- reset  in  1  asynchronous, active-high
- clock  in  1  rising-edge clock
- io_req  in  1  CPU request; held high until io_ack, then dropped
- io_func  in  [0:2]  0=SIO 1=TIO 2=TDV 3=HIO 6=AIO; other codes are unknown
- io_device  in  [21:31]  [21:23] IOP number, [24:31] device number
- io_ack  out  1  one-cycle acknowledge
- io_cc  out  [0:1]  condition code; valid only while io_ack=1
- io_aio_device  out  [0:7]  device reported by AIO; valid with io_ack
- dev_active  out  [0:NDEV-1]  one-hot active line to each device controller
- dev_done  in  [0:NDEV-1]  single-cycle completion pulse from a device
- mem_owner  out  1  1 = IOP drives the memory port; 0 = CPU drives it
- irq  out  1  completion or abort interrupt pending

Behaviour:
- Reset values:
  - io_ack=0, io_cc=0, io_aio_device=0, dev_active=0, mem_owner=0, irq=0.
  - Both FSMs idle; timeout counter=0; error flag=0; pending device=0.
- Request FSM:
  - States REQ_IDLE → REQ_ACK → REQ_WAIT.
  - In REQ_IDLE, io_req=1 latches io_func and io_device, then moves to REQ_ACK.
  - REQ_ACK: io_ack=1 for exactly one cycle, with io_cc computed from the channel state of the same cycle. Latency from req to ack is 1 cycle.
  - REQ_WAIT: stays until io_req=0, then returns to REQ_IDLE. A held io_req never produces a second ack.
- Addressing:
  - The target is absent if io_device[21:23] differs from IOP_NUM, or the device number is ≥ NDEV, or its PRESENT_MASK bit is 0.
  - AIO does not use the address.
- Condition codes:
  - SIO:
    - Absent → 11.
    - Channel not idle, or irq pending → 01, no action.
    - Otherwise → 00, and the channel starts the device.
  - TIO/TDV:
    - Absent → 11.
    - Target is the running device → 01.
    - Otherwise → 00; TDV returns 10 instead of 00 if the last operation on that device ended in error.
  - HIO:
    - Absent → 11.
    - Target running → abort it, 00.
    - Otherwise → 00, no effect.
  - AIO:
    - irq pending → cc = {error, 0}, io_aio_device = pending device; irq and error are cleared.
    - No irq pending → 11, io_aio_device=0.
  - Unknown func → 11, no action.
- Channel FSM:
  - States CH_IDLE → CH_RUN → CH_DRAIN → CH_IDLE.
  - Accepted SIO → CH_RUN on the cycle after ack.
  - CH_RUN:
    - dev_active[d]=1 and mem_owner=1.
    - Timeout counter increments each cycle, starting from 0.
  - CH_RUN exits to CH_DRAIN on any of:
    - dev_done[d]=1: normal completion, error=0.
    - Counter reaches TIMEOUT-1: error=1.
    - Accepted HIO: error=1.
  - dev_done bits of non-running devices are ignored.
  - CH_DRAIN: exactly one cycle with dev_active=0 and mem_owner=0 so the controller resets its phase. On entry, irq=1 and the pending device is set to d.
- Simultaneous events:
  - dev_done and HIO in the same cycle → normal completion, error=0, HIO cc=00.
  - dev_done and timeout in the same cycle → normal completion.
  - SIO arriving while the channel is in CH_DRAIN → 01.
- dev_active is never asserted for more than one bit; mem_owner equals the OR of dev_active.
- Asynchronous reset in mid-operation drops dev_active and mem_owner immediately, with no irq.

Decomposition:
- Shared package holds:
  - Function codes FNC_SIO/TIO/TDV/HIO/AIO.
  - CC constants CC_OK=00, CC_BUSY=01, CC_ERR=10, CC_NODEV=11.
  - Device numbers DEV_CONSOLE=1 and DEV_PAPERTAPE=5.
  - State encodings.
- One sub-module, iop_cc_decode: combinational request → cc/action decode.

Test Plan:
- SIO to device 5 while idle → ack 1 cycle after req with cc=00; next cycle dev_active[5]=1 and mem_owner=1; dev_done[5] pulse → 1 drain cycle with dev_active=0, then irq=1.
- SIO to device 3 (absent), and SIO with io_device[21:23]=1 → cc=11; dev_active stays 0.
- Device 1 running: SIO device 5 → cc=01; TIO device 1 → 01; TIO device 5 → 00.
- Device 1 running: HIO device 1 → cc=00; dev_active low in the following drain cycle; irq=1; AIO → cc=10, io_aio_device=1; irq clears; TDV device 1 → cc=10.
- Device never sends done → abort exactly TIMEOUT cycles after entering CH_RUN; AIO → cc=10; a second AIO → cc=11.
- dev_done[1] and HIO device 1 land in the same cycle → AIO cc=00; separately, reset asserted mid-run → all outputs 0 asynchronously.
